// File: rtl/cluster_sbit_expander.sv
// Rebuilds the per-pad S-bit map from a stream of cluster words (address + count).
// Optional macro CLUSTER_OVERLAP_DET_EN flags clusters that hit pads already set in the frame.
module cluster_sbit_expander #(
    parameter int MXROWS    = 8,
    parameter int MXKEYS    = 192,
    parameter int MXPADS    = MXROWS*MXKEYS,
    parameter int MXADRBITS = 11,
    parameter int MXCNTBITS = 3,
    parameter int MXCLUST   = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cluster_valid,
    output logic                 cluster_ready,
    input  logic [MXADRBITS-1:0] cluster_adr,
    input  logic [MXCNTBITS-1:0] cluster_cnt,
    input  logic                 frame_end,
    output logic [MXPADS-1:0]    sbits,
    output logic                 sbits_valid,
    output logic                 frame_overflow,
    output logic [4:0]           frame_nclust,
    output logic [7:0]           bad_adr_cnt,
    output logic                 overlap
);

    localparam logic [MXADRBITS-1:0] NPADS    = MXADRBITS'(MXPADS);
    localparam logic [MXADRBITS-1:0] KEYS     = MXADRBITS'(MXKEYS);
    localparam logic [MXADRBITS-1:0] SENTINEL = MXADRBITS'(11'h7FE);
    localparam logic [4:0]           NCLUST   = 5'(MXCLUST);

    logic                 reset_q;
    logic [4:0]           acc_cnt;
    logic                 ovf_trk;
    logic [MXPADS-1:0]    work;

    logic                 accept;
    logic                 adr_good;
    logic                 adr_bad;
    logic                 cnt_inc;
    logic                 refused;
    logic [MXADRBITS-1:0] row;
    logic [MXADRBITS-1:0] row_base;
    logic [MXADRBITS-1:0] key;
    logic [MXADRBITS-1:0] key_end;
    logic [MXADRBITS-1:0] last_pad;
    logic [MXPADS-1:0]    clmask;
    logic [MXPADS-1:0]    accmask;

    assign cluster_ready = !reset_q && (acc_cnt < NCLUST);
    assign accept        = cluster_valid && cluster_ready;
    assign refused       = cluster_valid && !cluster_ready;
    assign adr_good      = cluster_adr < NPADS;
    assign adr_bad       = !adr_good && (cluster_adr != SENTINEL);
    assign cnt_inc       = accept && adr_good;

    // Clamp the cluster end to the last key of its own partition.
    always_comb begin
        row      = cluster_adr / KEYS;
        row_base = row * KEYS;
        key      = cluster_adr - row_base;
        key_end  = key + {{(MXADRBITS-MXCNTBITS){1'b0}}, cluster_cnt};
        if (key_end > KEYS - 1'b1)
            key_end = KEYS - 1'b1;
        last_pad = row_base + key_end;
    end

    for (genvar g = 0; g < MXPADS; g++) begin : g_pad
        localparam logic [MXADRBITS-1:0] PADIDX = MXADRBITS'(g);
        assign clmask[g] = adr_good && (PADIDX >= cluster_adr)
                                    && (PADIDX <= last_pad);
    end

    assign accmask = accept ? clmask : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            reset_q        <= 1'b1;
            acc_cnt        <= '0;
            ovf_trk        <= 1'b0;
            work           <= '0;
            sbits          <= '0;
            sbits_valid    <= 1'b0;
            frame_overflow <= 1'b0;
            frame_nclust   <= '0;
            bad_adr_cnt    <= '0;
        end else begin
            reset_q     <= 1'b0;
            sbits_valid <= 1'b0;
            if (accept && adr_bad && bad_adr_cnt != 8'hFF)
                bad_adr_cnt <= bad_adr_cnt + 8'd1;
            if (frame_end) begin
                sbits          <= work | accmask;
                sbits_valid    <= 1'b1;
                frame_overflow <= ovf_trk | refused;
                frame_nclust   <= acc_cnt + {4'b0, cnt_inc};
                work           <= '0;
                acc_cnt        <= '0;
                ovf_trk        <= 1'b0;
            end else begin
                work    <= work | accmask;
                acc_cnt <= acc_cnt + {4'b0, cnt_inc};
                ovf_trk <= ovf_trk | refused;
            end
        end
    end

`ifdef CLUSTER_OVERLAP_DET_EN
    logic ovl_trk;
    logic ovl_hit;

    assign ovl_hit = |(accmask & work);

    always_ff @(posedge clock) begin
        if (reset) begin
            ovl_trk <= 1'b0;
            overlap <= 1'b0;
        end else if (frame_end) begin
            overlap <= ovl_trk | ovl_hit;
            ovl_trk <= 1'b0;
        end else begin
            ovl_trk <= ovl_trk | ovl_hit;
        end
    end
`else
    assign overlap = 1'b0;
`endif

endmodule
